// File: rtl/conv_tile_loader_if.sv
// Valid/ready stream bundle feeding conv_tile_loader.
// Carries the tile element stream (in_*) and the kernel weight stream (k_*).
interface conv_tile_loader_if #(
    parameter int DW = 8,
    parameter int KW = 8
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] k_data;
    logic          k_valid;
    logic          k_ready;

    modport master (
        output in_data, in_valid, k_data, k_valid,
        input  in_ready, k_ready
    );

    modport slave (
        input  in_data, in_valid, k_data, k_valid,
        output in_ready, k_ready
    );
endinterface

// File: rtl/conv_tile_loader.sv
// Packs serial tile elements and kernel weights into flat buses for the
// conv stage, then holds them under a level start (tile_valid) until tile_done.
// Ports: clk, reset (sync, active-high); bus (slave) carries the element and
// kernel streams; inp_data/kernel_data are the packed buses; tile_valid and
// tile_done form the start/completion pair; kernel_loaded flags a complete
// kernel; tile_count counts completed tiles.
module conv_tile_loader #(
    parameter int KERNEL_SIZE       = 3,
    parameter int INPUT_TILE_SIZE   = 4,
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int CHANNELS          = 3
) (
    input  logic clk,
    input  logic reset,
    conv_tile_loader_if.slave bus,
    output logic [CHANNELS*INPUT_TILE_SIZE*INPUT_TILE_SIZE*INPUT_DATA_WIDTH-1:0]
                 inp_data,
    output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH-1:0]
                 kernel_data,
    output logic        tile_valid,
    input  logic        tile_done,
    output logic        kernel_loaded,
    output logic [15:0] tile_count
);
    localparam int TE  = CHANNELS * INPUT_TILE_SIZE * INPUT_TILE_SIZE;
    localparam int KE  = CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int EW  = $clog2(TE);
    localparam int KCW = $clog2(KE);
    localparam logic [EW-1:0]  E_LAST = EW'(TE - 1);
    localparam logic [KCW-1:0] K_LAST = KCW'(KE - 1);

    typedef enum logic [1:0] {
        FILL,
        WAIT_K,
        RUN,
        RELEASE
    } state_t;

    state_t         state;
    logic [EW-1:0]  e_cnt;
    logic [KCW-1:0] k_cnt;
    logic           e_xfer;
    logic           k_xfer;

    // Readiness depends on state only, so the conv buses stay frozen in RUN.
    assign bus.in_ready = (state == FILL);
    assign bus.k_ready  = (state != RUN);
    assign e_xfer = bus.in_valid && bus.in_ready;
    assign k_xfer = bus.k_valid && bus.k_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FILL;
            e_cnt         <= '0;
            k_cnt         <= '0;
            inp_data      <= '0;
            kernel_data   <= '0;
            tile_valid    <= 1'b0;
            kernel_loaded <= 1'b0;
            tile_count    <= '0;
        end else begin
            // Kernel path: a word at index 0 over a held kernel starts an
            // in-place reload, so the kernel is no longer complete.
            if (k_xfer) begin
                kernel_data[k_cnt*KERNEL_DATA_WIDTH +: KERNEL_DATA_WIDTH]
                    <= bus.k_data;
                if (k_cnt == K_LAST) begin
                    k_cnt         <= '0;
                    kernel_loaded <= 1'b1;
                end else begin
                    k_cnt <= k_cnt + 1'b1;
                    if (k_cnt == '0 && kernel_loaded)
                        kernel_loaded <= 1'b0;
                end
            end

            unique case (state)
                FILL: begin
                    if (e_xfer) begin
                        inp_data[e_cnt*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]
                            <= bus.in_data;
                        if (e_cnt == E_LAST) begin
                            e_cnt <= '0;
                            // Registered flag: a kernel finishing on this
                            // same edge is picked up via WAIT_K.
                            if (kernel_loaded) begin
                                state      <= RUN;
                                tile_valid <= 1'b1;
                            end else begin
                                state <= WAIT_K;
                            end
                        end else begin
                            e_cnt <= e_cnt + 1'b1;
                        end
                    end
                end
                WAIT_K: begin
                    if (kernel_loaded) begin
                        state      <= RUN;
                        tile_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (tile_done) begin
                        state      <= RELEASE;
                        tile_valid <= 1'b0;
                        tile_count <= tile_count + 1'b1;
                    end
                end
                RELEASE: begin
                    // Wait for the completion flag to drop so a stale
                    // flag never completes the next tile.
                    if (!tile_done)
                        state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_tile_loader.sv
// Randomised self-checking bench for conv_tile_loader with a per-cycle
// behavioural model and directed literal checks.
module tb_conv_tile_loader;
    localparam int TE = 48;
    localparam int KE = 27;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tile_done = 1'b0;
    logic [TE*8-1:0] inp_data;
    logic [KE*8-1:0] kernel_data;
    logic tile_valid;
    logic kernel_loaded;
    logic [15:0] tile_count;

    conv_tile_loader_if #(.DW(8), .KW(8)) bus ();

    conv_tile_loader dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .inp_data     (inp_data),
        .kernel_data  (kernel_data),
        .tile_valid   (tile_valid),
        .tile_done    (tile_done),
        .kernel_loaded(kernel_loaded),
        .tile_count   (tile_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: byte arrays plus phase of the tile lifecycle.
    typedef enum {P_FILL, P_WAIT, P_RUN, P_REL} phase_t;
    phase_t      m_ph;
    logic [7:0]  m_tile [TE];
    logic [7:0]  m_kern [KE];
    int          m_e;
    int          m_k;
    bit          m_kl;
    int          m_cnt;

    task automatic model_clear();
        m_ph = P_FILL;
        m_e = 0;
        m_k = 0;
        m_kl = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < TE; i++) m_tile[i] = 8'h00;
        for (int i = 0; i < KE; i++) m_kern[i] = 8'h00;
    endtask

    always @(posedge clk) begin
        bit old_kl;
        bit ix;
        bit kx;
        if (reset) begin
            model_clear();
        end else begin
            old_kl = m_kl;
            ix = bus.in_valid && (m_ph == P_FILL);
            kx = bus.k_valid && (m_ph != P_RUN);
            if (kx) begin
                m_kern[m_k] = bus.k_data;
                if (m_k == 0 && old_kl) m_kl = 1'b0;
                m_k = m_k + 1;
                if (m_k == KE) begin
                    m_k = 0;
                    m_kl = 1'b1;
                end
            end
            case (m_ph)
                P_FILL: if (ix) begin
                    m_tile[m_e] = bus.in_data;
                    m_e = m_e + 1;
                    if (m_e == TE) begin
                        m_e = 0;
                        m_ph = old_kl ? P_RUN : P_WAIT;
                    end
                end
                P_WAIT: if (old_kl) m_ph = P_RUN;
                P_RUN: if (tile_done) begin
                    m_ph = P_REL;
                    m_cnt = (m_cnt + 1) % 65536;
                end
                P_REL: if (!tile_done) m_ph = P_FILL;
                default: ;
            endcase
        end
    end

    // Compare process: every cycle, just after the active edge.
    always @(posedge clk) begin
        logic [TE*8-1:0] et;
        logic [KE*8-1:0] ek;
        #1;
        if (chk_en) begin
            for (int i = 0; i < TE; i++) et[i*8 +: 8] = m_tile[i];
            for (int i = 0; i < KE; i++) ek[i*8 +: 8] = m_kern[i];
            checks++;
            if (inp_data !== et) begin
                errors++;
                $display("FAIL inp_data act=%h exp=%h", inp_data, et);
            end
            checks++;
            if (kernel_data !== ek) begin
                errors++;
                $display("FAIL kernel_data act=%h exp=%h", kernel_data, ek);
            end
            chk("tile_valid", 64'(tile_valid), 64'(m_ph == P_RUN));
            chk("in_ready", 64'(bus.in_ready), 64'(m_ph == P_FILL));
            chk("k_ready", 64'(bus.k_ready), 64'(m_ph != P_RUN));
            chk("kernel_loaded", 64'(kernel_loaded), 64'(m_kl));
            chk("tile_count", 64'(tile_count), 64'(m_cnt));
        end
    end

    // Driver tasks start and end on a falling edge.
    task automatic push_e(input logic [7:0] d);
        bit r;
        int t = 0;
        bus.in_data = d;
        bus.in_valid = 1'b1;
        forever begin
            r = bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            t++;
            if (t > 200) begin
                chk("push_e_timeout", 64'(t), 64'd0);
                break;
            end
        end
    endtask

    task automatic push_k(input logic [7:0] d);
        bit r;
        int t = 0;
        bus.k_data = d;
        bus.k_valid = 1'b1;
        forever begin
            r = bus.k_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            t++;
            if (t > 200) begin
                chk("push_k_timeout", 64'(t), 64'd0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.k_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic load_kernel(input int mode, input bit gaps);
        for (int i = 0; i < KE; i++) begin
            if (gaps && $urandom_range(1, 0) == 1) idle(1);
            push_k(mode == 0 ? 8'(i + 1) : mode == 1 ? 8'hFF : 8'($urandom));
        end
        bus.k_valid = 1'b0;
    endtask

    task automatic stream_tile(input int first, input int n,
                               input bit rnd, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            if (gaps && $urandom_range(1, 0) == 1) idle(1);
            push_e(rnd ? 8'($urandom) : 8'(i));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_tv(input bit v);
        int t = 0;
        while (tile_valid !== v && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("wait_tile_valid", 64'(tile_valid), 64'(v));
    endtask

    task automatic finish_tile(input int hold);
        tile_done = 1'b1;
        repeat (hold) @(negedge clk);
        wait_tv(1'b0);
        tile_done = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rel", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.k_valid = 1'b0;
        tile_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.k_data = '0;
        bus.k_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_tile_valid", 64'(tile_valid), 64'd0);
        chk("rst_tile_count", 64'(tile_count), 64'd0);
        chk("rst_inp_data", 64'(inp_data[63:0]), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;

        // 1: kernel 1..27, then elements 0..47 back to back.
        load_kernel(0, 1'b0);
        chk("t1_kernel_loaded", 64'(kernel_loaded), 64'd1);
        stream_tile(0, TE, 1'b0, 1'b0);
        chk("t1_tile_valid", 64'(tile_valid), 64'd1);
        chk("t1_byte0", 64'(inp_data[7:0]), 64'h00);
        chk("t1_byte47", 64'(inp_data[47*8 +: 8]), 64'h2F);
        chk("t1_kbyte26", 64'(kernel_data[26*8 +: 8]), 64'h1B);
        chk("t1_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t1_k_ready", 64'(bus.k_ready), 64'd0);

        // 3: tile_done held 3 cycles.
        tile_done = 1'b1;
        @(negedge clk);
        chk("t3_tile_valid", 64'(tile_valid), 64'd0);
        chk("t3_tile_count", 64'(tile_count), 64'd1);
        repeat (2) @(negedge clk);
        chk("t3_in_ready_hold", 64'(bus.in_ready), 64'd0);
        tile_done = 1'b0;
        @(negedge clk);
        chk("t3_in_ready", 64'(bus.in_ready), 64'd1);

        // 2: tile with no kernel, then kernel arrives.
        do_reset();
        stream_tile(0, TE, 1'b1, 1'b0);
        idle(2);
        chk("t2_tile_valid", 64'(tile_valid), 64'd0);
        chk("t2_k_ready", 64'(bus.k_ready), 64'd1);
        chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
        load_kernel(2, 1'b0);
        chk("t2_kl", 64'(kernel_loaded), 64'd1);
        chk("t2_tv_lag", 64'(tile_valid), 64'd0);
        @(negedge clk);
        chk("t2_tv", 64'(tile_valid), 64'd1);
        finish_tile(1);

        // 4: random tiles with gaps and kernel pulses during RUN.
        for (int n = 0; n < 4; n++) begin
            stream_tile(0, TE, 1'b1, 1'b1);
            wait_tv(1'b1);
            for (int j = 0; j < 4; j++) begin
                bus.k_data = 8'($urandom);
                bus.k_valid = $urandom_range(1, 0) == 1;
                @(negedge clk);
            end
            bus.k_valid = 1'b0;
            finish_tile($urandom_range(3, 0));
        end
        chk("t4_tile_count", 64'(tile_count), 64'd5);

        // Last element and last kernel word on the same edge.
        do_reset();
        stream_tile(0, TE - 1, 1'b0, 1'b0);
        for (int i = 0; i < KE - 1; i++) push_k(8'(i + 100));
        bus.in_data = 8'hAA;
        bus.in_valid = 1'b1;
        bus.k_data = 8'hBB;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.k_valid = 1'b0;
        chk("sim_kl", 64'(kernel_loaded), 64'd1);
        chk("sim_tv_lag", 64'(tile_valid), 64'd0);
        @(negedge clk);
        chk("sim_tv", 64'(tile_valid), 64'd1);
        finish_tile(0);

        // 5: reset after element 20 of tile 2.
        stream_tile(0, 21, 1'b1, 1'b0);
        do_reset();
        chk("t5_inp", 64'(inp_data[63:0]), 64'd0);
        chk("t5_kernel", 64'(kernel_data[63:0]), 64'd0);
        chk("t5_kl", 64'(kernel_loaded), 64'd0);
        chk("t5_count", 64'(tile_count), 64'd0);
        load_kernel(0, 1'b1);
        stream_tile(0, TE, 1'b0, 1'b1);
        wait_tv(1'b1);
        finish_tile(2);
        chk("t5_count1", 64'(tile_count), 64'd1);

        // 6: reload with all 0xFF between tiles.
        push_k(8'hFF);
        bus.k_valid = 1'b0;
        chk("t6_kl_drop", 64'(kernel_loaded), 64'd0);
        for (int i = 1; i < KE; i++) push_k(8'hFF);
        bus.k_valid = 1'b0;
        chk("t6_kl_back", 64'(kernel_loaded), 64'd1);
        stream_tile(0, TE, 1'b1, 1'b1);
        wait_tv(1'b1);
        chk("t6_k_lo", 64'(kernel_data[63:0]), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_k_hi", 64'(kernel_data[KE*8-1 -: 64]), 64'hFFFF_FFFF_FFFF_FFFF);
        finish_tile(1);
        chk("t6_count", 64'(tile_count), 64'd2);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/conv_tile_loader.md
Name: conv_tile_loader

Overview:
- Upstream feeder for the tile convolution stage.
- Accepts a serial stream of input-tile elements and a serial stream of kernel weights, each with a valid/ready handshake.
- Packs both into the flat bus layout the convolution stage consumes, then holds them stable under a level-type start (tile_valid) until the stage reports completion (tile_done).
- Sequences one tile at a time and counts completed tiles.

Parameters:
KERNEL_SIZE, 3, kernel edge length
INPUT_TILE_SIZE, 4, input tile edge length
INPUT_DATA_WIDTH, 8, bits per input element
KERNEL_DATA_WIDTH, 8, bits per kernel weight
CHANNELS, 3, channel count
Derived: TILE_ELEMS = CHANNELS*INPUT_TILE_SIZE^2 (48); KERN_ELEMS = CHANNELS*KERNEL_SIZE^2 (27)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_data  in  INPUT_DATA_WIDTH  input tile element
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept in_data
k_data  in  KERNEL_DATA_WIDTH  kernel weight
k_valid  in  1  k_data valid
k_ready  out  1  loader can accept k_data
inp_data  out  TILE_ELEMS*INPUT_DATA_WIDTH  packed tile to conv stage
kernel_data  out  KERN_ELEMS*KERNEL_DATA_WIDTH  packed kernel to conv stage
tile_valid  out  1  conv start, level
tile_done  in  1  conv completion flag, level
kernel_loaded  out  1  a complete kernel is held
tile_count  out  16  tiles completed, wraps at 65535->0

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk. Everything is on the rising edge of clk.
- Reset values:
  - inp_data, kernel_data = 0
  - tile_valid, kernel_loaded = 0
  - tile_count = 0
  - element and kernel counters = 0
  - state = FILL
- Reset wins over every other event, including mid-tile and during RUN. The partial tile and the kernel are both discarded.
- Packing order matches the conv stage: channel-major, then row, then column. Element e is written to inp_data[e*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]. Kernel word k is written to kernel_data[k*KERNEL_DATA_WIDTH +: KERNEL_DATA_WIDTH].
- Handshakes:
  - A transfer occurs only when valid and ready are both 1 on a rising edge.
  - in_ready and k_ready are combinational from state only. They never depend on valid.
  - in_ready = (state==FILL).
  - k_ready = (state!=RUN), so the kernel is never modified while conv is running.
- Kernel path:
  - k_cnt 0..KERN_ELEMS-1; it wraps to 0 on accepting word KERN_ELEMS-1, and kernel_loaded is set to 1 at that edge.
  - Accepting any word with k_cnt==0 while kernel_loaded=1 clears kernel_loaded on that edge; this starts a reload that overwrites in place.
- FSM states: FILL, WAIT_K, RUN, RELEASE.
  - FILL: accepts elements; e_cnt increments per transfer. On accepting element TILE_ELEMS-1: e_cnt becomes 0, and next state is RUN if kernel_loaded (registered value that cycle) is 1, else WAIT_K.
  - WAIT_K: in_ready=0. Go to RUN when kernel_loaded is 1.
  - RUN: tile_valid=1 (registered, high for the whole state). inp_data and kernel_data are frozen. On tile_done=1: go to RELEASE and increment tile_count.
  - RELEASE: tile_valid=0. Stay until tile_done=0, then go to FILL. This guarantees a stale completion flag is never taken as completion of the next tile.
- Latency:
  - Last element accepted at edge N with kernel ready -> tile_valid=1 after edge N.
  - tile_done seen at edge M -> tile_valid=0 after edge M.
  - Minimum gap between tiles = TILE_ELEMS + 2 cycles.
- Simultaneous events:
  - Last tile element and last kernel word accepted on the same edge -> via WAIT_K, tile_valid rises one cycle later.
  - tile_done asserted in any state other than RUN is ignored.
- No backpressure timeout. Holding in_valid=0 in FILL simply stalls.

Test Plan:
1. Reset, load 27 kernel words 1..27, then stream 48 elements 0..47 with in_valid held high -> kernel_loaded=1 after the 27th word; tile_valid rises the cycle after element 47; inp_data byte 0=0x00, byte 47=0x2F; kernel_data byte 26=0x1B; in_ready=0 and k_ready=0 during RUN.
2. Stream 48 elements with no kernel loaded -> FSM in WAIT_K, tile_valid=0, k_ready=1; load 27 weights -> tile_valid=1 the cycle after kernel_loaded rises.
3. In RUN, hold tile_done=1 for 3 cycles, then drop it -> tile_valid falls after the first edge, tile_count=1, in_ready stays 0 until tile_done=0, then in_ready=1.
4. Random in_valid gaps (50%), and k_valid pulses during RUN -> every element lands at its correct packed index; kernel words offered during RUN are not accepted (k_ready=0) and kernel_data is unchanged.
5. Assert reset after element 20 of tile 2 -> all outputs are 0 on the next cycle and kernel_loaded=0; a full reload then produces a correct tile with tile_count restarting at 0→1.
6. Kernel reload between tiles (weights all 0xFF) -> kernel_loaded drops on the first new word and returns to 1 on the 27th; the next tile runs with kernel_data all 0xFF.
